// File: rtl/sb_spram256ka.sv
// Behavioural single-port 16K x 16 SPRAM with per-nibble write masking
// and standby / sleep / power-gate controls; registered read data.
module sb_spram256ka #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  wren,
    input  logic [3:0]            maskwren,
    input  logic [15:0]           datain,
    input  logic                  standby,
    input  logic                  sleep,
    input  logic                  poweroff,
    output logic [15:0]           dataout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [15:0] mem_q [DEPTH];
    logic [15:0] dataout_d, dataout_q;
    logic        active;

    // Reset level also blocks the array so a write sampled during reset is dropped.
    assign active = poweroff & ~sleep & ~standby & chipselect & ~reset;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (active && wren && maskwren[i]) begin
                mem_q[address][4*i +: 4] <= datain[4*i +: 4];
            end
        end
    end

    always_comb begin
        dataout_d = dataout_q;
        if (sleep) begin
            dataout_d = 16'h0000;
        end else if (active && !wren) begin
            dataout_d = mem_q[address];
        end
    end

    // Power gate (active low) clears the output as asynchronously as reset does.
    always_ff @(posedge clk or posedge reset or negedge poweroff) begin
        if (reset || !poweroff) begin
            dataout_q <= 16'h0000;
        end else begin
            dataout_q <= dataout_d;
        end
    end

    assign dataout = dataout_q;

endmodule

// File: tb/tb_sb_spram256ka.sv
// Scoreboard bench for sb_spram256ka: stimulus queues expected dataout values,
// a monitor pops and compares them half a cycle after the sampling edge.
module tb_sb_spram256ka;

    logic        clk = 1'b0;
    logic        reset, chipselect, wren, standby, sleep, poweroff;
    logic [13:0] address;
    logic [3:0]  maskwren;
    logic [15:0] datain, dataout;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic chk_req = 1'b0;
    logic chk_vld = 1'b0;

    sb_spram256ka #(.ADDR_WIDTH(14)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .wren(wren), .maskwren(maskwren), .datain(datain), .standby(standby),
        .sleep(sleep), .poweroff(poweroff), .dataout(dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: dataout=%h expected=%h", name, act, exp);
    endtask

    // Monitor: an expectation issued before edge N is compared after edge N.
    always @(posedge clk) chk_vld <= chk_req;

    always @(negedge clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL scoreboard_underflow: dataout=%h expected=none", dataout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, dataout, e.exp);
            end
        end
    end

    task automatic drive(input logic cs, input logic we, input logic [3:0] m,
                         input logic [13:0] a, input logic [15:0] d,
                         input logic sb, input logic sl);
        @(negedge clk);
        chipselect = cs; wren = we; maskwren = m; address = a; datain = d;
        standby = sb; sleep = sl; chk_req = 1'b0;
    endtask

    task automatic expect_after(input logic [15:0] exp, input string name);
        exp_t e;
        e.exp = exp; e.name = name;
        exp_q.push_back(e);
        chk_req = 1'b1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
        drive(1'b1, 1'b1, m, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string name);
        drive(1'b1, 1'b0, 4'hF, a, 16'h0000, 1'b0, 1'b0);
        expect_after(exp, name);
    endtask

    task automatic hold(input logic cs, input logic we, input logic [13:0] a,
                        input logic sb, input logic sl, input logic [15:0] exp, input string name);
        drive(cs, we, 4'hF, a, 16'hDEAD, sb, sl);
        expect_after(exp, name);
    endtask

    initial begin
        reset = 1'b1; poweroff = 1'b1; chipselect = 1'b0; wren = 1'b0;
        maskwren = 4'h0; address = '0; datain = '0; standby = 1'b0; sleep = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dataout, 16'h0000);
        reset = 1'b0;
        hold(1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 16'h0000, "post_reset_idle");

        // basic read/write at both address extremes
        wr(14'h0000, 16'hA5C3, 4'hF);
        wr(14'h3FFF, 16'h1234, 4'hF);
        rd(14'h0000, 16'hA5C3, "rd_addr0");
        rd(14'h3FFF, 16'h1234, "rd_addr3fff");

        // nibble masking
        wr(14'h0010, 16'hFFFF, 4'hF);
        wr(14'h0010, 16'h0000, 4'b0101);
        rd(14'h0010, 16'hF0F0, "mask_0101");
        wr(14'h0010, 16'h0000, 4'b0000);
        rd(14'h0010, 16'hF0F0, "mask_0000");
        wr(14'h0010, 16'h0BC0, 4'b0110);
        rd(14'h0010, 16'hFBC0, "mask_0110");
        wr(14'h0010, 16'hF0F0, 4'b0110);
        rd(14'h0010, 16'hF0F0, "read_after_write");

        // hold conditions: chipselect low, then standby with writes attempted
        rd(14'h3FFF, 16'h1234, "rd_before_hold");
        hold(1'b0, 1'b1, 14'h0000, 1'b0, 1'b0, 16'h1234, "cs_low_hold");
        hold(1'b0, 1'b0, 14'h0010, 1'b0, 1'b0, 16'h1234, "cs_low_hold_rd");
        hold(1'b1, 1'b1, 14'h0000, 1'b1, 1'b0, 16'h1234, "standby_wr0");
        hold(1'b1, 1'b1, 14'h3FFF, 1'b1, 1'b0, 16'h1234, "standby_wr3fff");
        hold(1'b1, 1'b1, 14'h0010, 1'b1, 1'b0, 16'h1234, "standby_wr10");
        hold(1'b1, 1'b0, 14'h0000, 1'b1, 1'b0, 16'h1234, "standby_rd");
        rd(14'h0000, 16'hA5C3, "standby_no_mod0");
        rd(14'h3FFF, 16'h1234, "standby_no_mod3fff");
        rd(14'h0010, 16'hF0F0, "standby_no_mod10");

        // sleep forces zero, retains contents, blocks writes
        hold(1'b1, 1'b0, 14'h3FFF, 1'b0, 1'b1, 16'h0000, "sleep_zero");
        hold(1'b1, 1'b1, 14'h0000, 1'b0, 1'b1, 16'h0000, "sleep_wr_zero");
        rd(14'h0000, 16'hA5C3, "after_sleep");

        // async reset between edges
        rd(14'h3FFF, 16'h1234, "rd_before_reset");
        drive(1'b0, 1'b0, 4'hF, 14'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", dataout, 16'h0000);
        wr(14'h3FFF, 16'hBEEF, 4'hF);
        check("reset_hold", dataout, 16'h0000);
        drive(1'b0, 1'b0, 4'hF, 14'h0, 16'h0, 1'b0, 1'b0);
        reset = 1'b0;
        rd(14'h3FFF, 16'h1234, "write_in_reset_dropped");

        // async power-off
        rd(14'h0000, 16'hA5C3, "rd_before_poweroff");
        drive(1'b0, 1'b0, 4'hF, 14'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2 poweroff = 1'b0;
        #1 check("async_poweroff", dataout, 16'h0000);
        hold(1'b1, 1'b0, 14'h0000, 1'b0, 1'b0, 16'h0000, "poweroff_no_read");
        drive(1'b0, 1'b0, 4'hF, 14'h0, 16'h0, 1'b0, 1'b0);
        poweroff = 1'b1;
        wr(14'h0020, 16'h5A5A, 4'hF);
        rd(14'h0020, 16'h5A5A, "rewrite_after_power");

        // loader pattern, then back-to-back readback
        for (int i = 0; i < 16384; i++) wr(i[13:0], i[15:0], 4'hF);
        for (int i = 0; i < 16384; i++) rd(i[13:0], i[15:0], "seq_load");
        drive(1'b0, 1'b0, 4'hF, 14'h0, 16'h0, 1'b0, 1'b0);

        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sb_spram256ka.md
Name: sb_spram256ka

Overview:
- Single-port synchronous 16K x 16 RAM (256 Kbit) with per-nibble write masking and low-power controls.
- Behavioural model of the on-chip SPRAM block.
- Holds program ROM contents: a flash loader fills it at boot, then the CPU reads it one word per cycle.

Parameters:
- ADDR_WIDTH, 14, address bits; depth = 2^ADDR_WIDTH words (16384). Data width is fixed at 16.

Ports:
- clk  input  1  rising-edge clock for all accesses
- reset  input  1  asynchronous, active-high; clears the output register only
- chipselect  input  1  1 = access enabled this cycle
- address  input  14  word address
- wren  input  1  1 = write, 0 = read
- maskwren  input  4  per-nibble write enable: bit0 -> datain[3:0], bit1 -> [7:4], bit2 -> [11:8], bit3 -> [15:12]
- datain  input  16  write data
- standby  input  1  1 = standby: no access, contents retained, dataout held
- sleep  input  1  1 = sleep: no access, contents retained, dataout forced 0
- poweroff  input  1  active-LOW power gate: 1 = powered, 0 = off (contents lost)
- dataout  output  16  registered read data

Behaviour:
- Storage is a 16384 x 16 array. No reset of array contents. Initial array contents are unspecified.
- Define active = poweroff & !sleep & !standby & chipselect.
- reset (async, high):
  - dataout -> 16'h0000 immediately.
  - Array untouched.
  - While reset is high, no reads or writes occur.
- Write, on posedge clk with active & wren:
  - For each i in 0..3 with maskwren[i] = 1, mem[address][4i+3:4i] <= datain[4i+3:4i].
  - Unmasked nibbles are unchanged.
  - maskwren = 0000 writes nothing.
  - dataout holds its previous value during a write cycle (no write-through).
- Read, on posedge clk with active & !wren:
  - dataout <= mem[address].
  - Latency is 1 cycle: the address presented before edge N appears on dataout after edge N.
  - dataout holds until the next read, sleep, power-off or reset.
- Read-after-write: a read of an address at edge N+1, after a write to it at edge N, returns the new data.
- chipselect = 0: no access; dataout holds.
- standby = 1: no access; dataout holds; contents retained.
- sleep = 1:
  - dataout forced to 0 at the next edge and held at 0 while sleep is asserted.
  - Contents retained.
  - The first read after sleep deasserts behaves normally.
- poweroff = 0:
  - dataout forced to 0 asynchronously.
  - No access.
  - Array contents become unspecified; after power returns, valid data is returned only for locations rewritten since.
- Priority: reset > poweroff = 0 > sleep > standby > chipselect.
- Address is used in full; there is no out-of-range condition and no wrap logic.
- Simultaneous reset deassertion and a clock edge: the access at that edge is ignored; operation starts at the following edge.
- Reset asserted mid-operation: dataout clears and any write sampled at the same edge is dropped.

Test Plan:
- Basic read/write: reset, then write 16'hA5C3 to 0x0000, 16'h1234 to 0x3FFF (maskwren = 1111, chipselect = 1, poweroff = 1) -> reads return 16'hA5C3 and 16'h1234, each one cycle after the address is presented; dataout is 0 after reset.
- Nibble mask: write 16'hFFFF to 0x0010, then 16'h0000 with maskwren = 0101 -> read gives 16'hF0F0; maskwren = 0000 leaves the word unchanged.
- Sequential load: write mem[i] = i for i = 0..0x3FFF (loader pattern), then read back all 16384 locations -> each read returns i; back-to-back reads give one new word per cycle.
- Hold conditions: after reading 16'h1234, drop chipselect, then assert standby with a changing address and wren = 1 -> dataout stays 16'h1234 and no location is modified.
- Sleep: assert sleep -> dataout 0; deassert and read 0x0000 -> 16'hA5C3 (retained).
- Async reset: assert reset between clock edges while dataout = 16'h1234 -> dataout = 0 before the next edge; a write sampled during reset does not change memory.
